sram_history_logger: RTL and testbench

- Downstream of the neural-network decision stage: captures each decision record (scores, neuron outputs, direction, time change) and writes it as one five-word entry into the external SRAM ring buffer.
- Serves indexed read-back of past records to the calibrator over a request/valid handshake.
- Owns the SRAM port: address pointer, record count, write/read arbitration.

---
 rtl/sram_history_logger_if.sv | 29 ++
 rtl/sram_history_logger.sv | 198 +++++++++++++++++++
 tb/tb_sram_history_logger.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_history_logger_if.sv
// Decision-record capture channel: valid/ready handshake plus raw fields.
interface sram_history_logger_if;
  logic        log_valid;
  logic        log_ready;
  logic [6:0]  i_tns;
  logic [6:0]  i_tew;
  logic [6:0]  i_pns;
  logic [6:0]  i_pew;
  logic [13:0] i_ns_out;
  logic [13:0] i_ew_out;
  logic        i_dir;
  logic [7:0]  i_dtime;

  modport master (
    output log_valid,
    output i_tns, i_tew, i_pns, i_pew,
    output i_ns_out, i_ew_out,
    output i_dir, i_dtime,
    input  log_ready
  );

  modport slave (
    input  log_valid,
    input  i_tns, i_tew, i_pns, i_pew,
    input  i_ns_out, i_ew_out,
    input  i_dir, i_dtime,
    output log_ready
  );
endinterface

// File: rtl/sram_history_logger.sv
// Logs decision records into an SRAM ring and serves indexed read-back.
// Define HIST_OVERWRITE_EN to let a full ring overwrite its oldest record.
module sram_history_logger #(
  parameter int ADDR_W = 12,
  parameter int FIFO_D = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_history_logger_if.slave log_if,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_idx,
  output logic                 rd_busy,
  output logic                 rd_valid,
  output logic                 rd_err,
  output logic [6:0]           o_tns,
  output logic [6:0]           o_tew,
  output logic [6:0]           o_pns,
  output logic [6:0]           o_pew,
  output logic [13:0]          o_ns_out,
  output logic [13:0]          o_ew_out,
  output logic                 o_dir,
  output logic [7:0]           o_dtime,
  output logic [ADDR_W:0]      rec_count,
  output logic                 overflow,
  output logic                 read_enable,
  output logic                 write_enable,
  output logic [ADDR_W-1:0]    s_addr,
  output logic [15:0]          w_trafficIn,
  output logic [15:0]          w_pedIn,
  output logic [15:0]          w_NSout,
  output logic [15:0]          w_EWout,
  output logic [15:0]          w_dir_time,
  input  logic [15:0]          s_trafficIn,
  input  logic [15:0]          s_pedIn,
  input  logic [15:0]          s_NSout,
  input  logic [15:0]          s_EWout,
  input  logic [15:0]          s_dir_time
);
  localparam int FA = $clog2(FIFO_D);
  localparam logic [ADDR_W:0] DEPTH =
    {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WRITE      = 2'd1;
  localparam logic [1:0] RD_ISSUE   = 2'd2;
  localparam logic [1:0] RD_CAPTURE = 2'd3;

  logic [1:0]        state;
  logic [79:0]       mem [FIFO_D];
  logic [FA:0]       f_wp;
  logic [FA:0]       f_rp;
  logic              f_empty;
  logic              f_full;
  logic              push;
  logic              pop;
  logic [79:0]       in_word;
  logic [79:0]       head;
  logic [79:0]       w_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [ADDR_W-1:0] idx_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic              full;
  logic              drop;
  logic              rd_acc;
  logic              rd_bad;
  logic              rd_ok;
  logic              unused_s;

  assign f_empty = f_wp == f_rp;
  assign f_full  = (f_wp[FA] != f_rp[FA]) &&
                   (f_wp[FA-1:0] == f_rp[FA-1:0]);
  assign log_if.log_ready = !f_full;
  assign push = log_if.log_valid && !f_full;
  assign pop  = state == WRITE;

  assign in_word = {
    2'b00, log_if.i_tns, log_if.i_tew,
    2'b00, log_if.i_pns, log_if.i_pew,
    2'b00, log_if.i_ns_out,
    2'b00, log_if.i_ew_out,
    7'b0, log_if.i_dir, log_if.i_dtime
  };

  // Bypass lets a record pushed into an empty FIFO be written next cycle.
  assign head = f_empty ? in_word : mem[f_rp[FA-1:0]];

  assign full = rec_count == DEPTH;
`ifdef HIST_OVERWRITE_EN
  assign drop = 1'b0;
`else
  assign drop = full;
`endif

  assign rd_acc  = rd_req && !rd_busy;
  assign rd_bad  = rd_acc && ({1'b0, rd_idx} >= rec_count);
  assign rd_ok   = rd_acc && !rd_bad;
  assign idx_sel = rd_ok ? rd_idx : rd_idx_q;
  assign rd_addr = wr_ptr - ADDR_W'(1) - idx_sel;

  assign {w_trafficIn, w_pedIn, w_NSout,
          w_EWout, w_dir_time} = w_q;

  assign unused_s = ^{s_trafficIn[15:14], s_pedIn[15:14],
                      s_NSout[15:14], s_EWout[15:14],
                      s_dir_time[15:9]};

  always_ff @(posedge clk) begin
    if (push) mem[f_wp[FA-1:0]] <= in_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_wp <= '0;
      f_rp <= '0;
    end else begin
      if (push) f_wp <= f_wp + (FA+1)'(1);
      if (pop)  f_rp <= f_rp + (FA+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rec_count    <= '0;
      overflow     <= 1'b0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      s_addr       <= '0;
      w_q          <= '0;
      rd_idx_q     <= '0;
      rd_busy      <= 1'b0;
      rd_valid     <= 1'b0;
      rd_err       <= 1'b0;
      o_tns        <= '0;
      o_tew        <= '0;
      o_pns        <= '0;
      o_pew        <= '0;
      o_ns_out     <= '0;
      o_ew_out     <= '0;
      o_dir        <= 1'b0;
      o_dtime      <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= rd_bad;
      if (rd_ok) begin
        rd_busy  <= 1'b1;
        rd_idx_q <= rd_idx;
      end
      unique case (state)
        IDLE: begin
          if (!f_empty || push) begin
            state        <= WRITE;
            write_enable <= !drop;
            if (!drop) begin
              s_addr <= wr_ptr;
              w_q    <= head;
            end
          end else if (rd_busy || rd_ok) begin
            state       <= RD_ISSUE;
            read_enable <= 1'b1;
            s_addr      <= rd_addr;
          end
        end
        WRITE: begin
          state        <= IDLE;
          write_enable <= 1'b0;
          if (drop) begin
            overflow <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (!full)
              rec_count <= rec_count + (ADDR_W+1)'(1);
          end
        end
        RD_ISSUE: begin
          state       <= RD_CAPTURE;
          read_enable <= 1'b0;
        end
        RD_CAPTURE: begin
          state    <= IDLE;
          rd_valid <= 1'b1;
          rd_busy  <= 1'b0;
          o_tns    <= s_trafficIn[13:7];
          o_tew    <= s_trafficIn[6:0];
          o_pns    <= s_pedIn[13:7];
          o_pew    <= s_pedIn[6:0];
          o_ns_out <= s_NSout[13:0];
          o_ew_out <= s_EWout[13:0];
          o_dir    <= s_dir_time[8];
          o_dtime  <= s_dir_time[7:0];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_history_logger.sv
// Bench for sram_history_logger: queue model of the ring plus directed cases.
module tb_sram_history_logger;
`ifdef HIST_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  tns;
    logic [6:0]  tew;
    logic [6:0]  pns;
    logic [6:0]  pew;
    logic [13:0] ns;
    logic [13:0] ew;
    logic        dir;
    logic [7:0]  dt;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req = 1'b0;
  logic [2:0] rd_idx = '0;
  logic rd_busy, rd_valid, rd_err;
  logic [6:0] o_tns, o_tew, o_pns, o_pew;
  logic [13:0] o_ns_out, o_ew_out;
  logic o_dir;
  logic [7:0] o_dtime;
  logic [3:0] rec_count;
  logic overflow, read_enable, write_enable;
  logic [2:0] s_addr;
  logic [15:0] w_trafficIn, w_pedIn, w_NSout, w_EWout, w_dir_time;
  logic [15:0] s_trafficIn, s_pedIn, s_NSout, s_EWout, s_dir_time;

  sram_history_logger_if lif();

  sram_history_logger #(.ADDR_W(3), .FIFO_D(2)) dut (
    .clk(clk), .rst(rst), .log_if(lif),
    .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_err(rd_err),
    .o_tns(o_tns), .o_tew(o_tew), .o_pns(o_pns), .o_pew(o_pew),
    .o_ns_out(o_ns_out), .o_ew_out(o_ew_out),
    .o_dir(o_dir), .o_dtime(o_dtime),
    .rec_count(rec_count), .overflow(overflow),
    .read_enable(read_enable), .write_enable(write_enable),
    .s_addr(s_addr),
    .w_trafficIn(w_trafficIn), .w_pedIn(w_pedIn),
    .w_NSout(w_NSout), .w_EWout(w_EWout), .w_dir_time(w_dir_time),
    .s_trafficIn(s_trafficIn), .s_pedIn(s_pedIn),
    .s_NSout(s_NSout), .s_EWout(s_EWout), .s_dir_time(s_dir_time)
  );

  always #5 clk = ~clk;

  logic [79:0] sram [8];
  always @(posedge clk) begin
    if (write_enable)
      sram[s_addr] <= {w_trafficIn, w_pedIn, w_NSout, w_EWout, w_dir_time};
    if (read_enable)
      {s_trafficIn, s_pedIn, s_NSout, s_EWout, s_dir_time} <= sram[s_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [79:0] pk(input rec_t r);
    return {2'b0, r.tns, r.tew, 2'b0, r.pns, r.pew,
            2'b0, r.ns, 2'b0, r.ew, 7'b0, r.dir, r.dt};
  endfunction

  function automatic rec_t mk(input int k);
    rec_t r;
    r.tns = 7'(k * 11 + 3);
    r.tew = 7'(k * 5 + 64);
    r.pns = 7'(k * 3 + 9);
    r.pew = 7'(100 - k);
    r.ns  = 14'(k * 777 + 1);
    r.ew  = 14'(16383 - k * 99);
    r.dir = 1'(k);
    r.dt  = 8'(k * 37 + 200);
    return r;
  endfunction

  // Model: accepted-but-unwritten records, and the write history in order.
  rec_t acc_q[$];
  rec_t hist[$];
  rec_t exp_rd;
  logic [79:0] last_w;
  int acc_n, lat_idx;
  int n_we = 0, n_re = 0, n_valid = 0, n_err = 0;
  int n_acc = 0, n_stall = 0;
  int valid_cyc = 0, err_cyc = 0;

  always @(negedge clk) begin
    rec_t r;
    int j;
    if (rst) begin
      acc_q.delete();
      hist.delete();
      acc_n = 0;
      lat_idx = 0;
      last_w = '0;
      exp_rd = '0;
    end else begin
      check("strobe_excl", 80'(write_enable & read_enable), 80'd0);
      check("rec_count", 80'(rec_count),
            80'(hist.size() > 8 ? 8 : hist.size()));
      if (write_enable) begin
        n_we++;
        if (acc_q.size() == 0) begin
          check("spurious_write", 80'd1, 80'd0);
        end else begin
          r = acc_q.pop_front();
          check("w_addr", 80'(s_addr), 80'(hist.size() % 8));
          check("w_data", {w_trafficIn, w_pedIn, w_NSout,
                           w_EWout, w_dir_time}, pk(r));
          hist.push_back(r);
          last_w = pk(r);
        end
      end else begin
        check("w_hold", {w_trafficIn, w_pedIn, w_NSout,
                         w_EWout, w_dir_time}, last_w);
      end
      if (read_enable) begin
        n_re++;
        if (hist.size() > lat_idx) begin
          j = hist.size() - 1 - lat_idx;
          check("r_addr", 80'(s_addr), 80'(j % 8));
          exp_rd = hist[j];
        end else begin
          check("r_range", 80'd1, 80'd0);
        end
      end
      if (rd_valid) begin
        n_valid++;
        valid_cyc = cyc;
        check("rd_data", 80'({o_tns, o_tew, o_pns, o_pew, o_ns_out,
                              o_ew_out, o_dir, o_dtime}), 80'(exp_rd));
      end
      if (rd_err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (lif.log_valid && lif.log_ready) begin
        n_acc++;
        if (OVR || acc_n < 8)
          acc_q.push_back({lif.i_tns, lif.i_tew, lif.i_pns, lif.i_pew,
                           lif.i_ns_out, lif.i_ew_out, lif.i_dir,
                           lif.i_dtime});
        acc_n++;
      end
      if (lif.log_valid && !lif.log_ready) n_stall++;
      if (rd_req && !rd_busy) lat_idx = int'(rd_idx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input rec_t r);
    lif.i_tns = r.tns;   lif.i_tew = r.tew;
    lif.i_pns = r.pns;   lif.i_pew = r.pew;
    lif.i_ns_out = r.ns; lif.i_ew_out = r.ew;
    lif.i_dir = r.dir;   lif.i_dtime = r.dt;
  endtask

  task automatic push(input rec_t r);
    drive(r);
    lif.log_valid = 1'b1;
    tick();
    lif.log_valid = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] idx, input bit with_push,
                         input rec_t r, input bit exp_err,
                         input int exp_lat);
    int v0, e0, r0, t0;
    v0 = n_valid; e0 = n_err; r0 = n_re;
    if (with_push) begin
      drive(r);
      lif.log_valid = 1'b1;
    end
    rd_idx = idx;
    rd_req = 1'b1;
    t0 = cyc;
    tick();
    rd_req = 1'b0;
    lif.log_valid = 1'b0;
    check("rd_busy_rise", 80'(rd_busy), 80'(!exp_err));
    for (int k = 0; k < 30; k++) begin
      if (n_valid != v0 || n_err != e0) break;
      tick();
    end
    if (exp_err) begin
      check("rd_err_seen", 80'(n_err - e0), 80'd1);
      check("rd_err_lat", 80'(err_cyc - t0), 80'(exp_lat));
      check("rej_no_sram", 80'(n_re - r0), 80'd0);
      check("rej_busy", 80'(rd_busy), 80'd0);
    end else begin
      check("rd_valid_seen", 80'(n_valid - v0), 80'd1);
      check("rd_lat", 80'(valid_cyc - t0), 80'(exp_lat));
      check("rd_no_err", 80'(n_err - e0), 80'd0);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rec_t rs, m;
    int a0, w0, st0, v0, e0, t0;
    lif.log_valid = 1'b0;
    drive('0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_count", 80'(rec_count), 80'd0);
    check("rst_ready", 80'(lif.log_ready), 80'd1);
    check("rst_we", 80'(write_enable), 80'd0);
    check("rst_ovf", 80'(overflow), 80'd0);
    check("rst_busy", 80'(rd_busy), 80'd0);

    // Reset in the middle of a write.
    push(mk(1));
    check("pre_rst_we", 80'(write_enable), 80'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("mid_rst_we", 80'(write_enable), 80'd0);
    check("mid_rst_count", 80'(rec_count), 80'd0);
    check("mid_rst_ready", 80'(lif.log_ready), 80'd1);
    check("mid_rst_addr", 80'(s_addr), 80'd0);
    tick();

    // Single log with literal packing.
    rs = mk(2);
    rs.tns = 7'h15; rs.tew = 7'h2A; rs.dir = 1'b1; rs.dt = 8'hF6;
    push(rs);
    check("single_we", 80'(write_enable), 80'd1);
    check("single_addr", 80'(s_addr), 80'd0);
    check("single_traffic", 80'(w_trafficIn), 80'h0AAA);
    check("single_dirtime", 80'(w_dir_time), 80'h01F6);
    tick();
    check("single_count", 80'(rec_count), 80'd1);

    do_read(3'd1, 1'b0, '0, 1'b1, 1);

    push(mk(3)); tick(); tick();
    push(mk(4)); tick(); tick();
    do_read(3'd2, 1'b0, '0, 1'b0, 3);
    check("rb_addr", 80'(s_addr), 80'd0);
    check("rb_tns", 80'(o_tns), 80'h15);
    check("rb_dtime", 80'(o_dtime), 80'hF6);
    check("rb_dir", 80'(o_dir), 80'd1);
    do_read(3'd3, 1'b0, '0, 1'b1, 1);

    // A second request while busy must be ignored.
    v0 = n_valid; e0 = n_err;
    rd_idx = 3'd0; rd_req = 1'b1; t0 = cyc;
    tick();
    rd_idx = 3'd7;
    tick();
    rd_req = 1'b0;
    repeat (6) tick();
    check("busy_one_valid", 80'(n_valid - v0), 80'd1);
    check("busy_no_err", 80'(n_err - e0), 80'd0);
    check("busy_lat", 80'(valid_cyc - t0), 80'd3);
    m = mk(4);
    check("busy_data", 80'(o_tns), 80'(m.tns));

    // Collision: write goes first, then the read sees it as newest.
    m = mk(5);
    do_read(3'd0, 1'b1, m, 1'b0, 5);
    check("coll_tns", 80'(o_tns), 80'(m.tns));
    check("coll_ew", 80'(o_ew_out), 80'(m.ew));

    // Back-pressure.
    a0 = n_acc; w0 = n_we; st0 = n_stall;
    for (int k = 0; k < 4; k++) begin
      drive(mk(10 + k));
      lif.log_valid = 1'b1;
      tick();
    end
    lif.log_valid = 1'b0;
    repeat (10) tick();
    check("bp_stalled", 80'(n_stall > st0), 80'd1);
    check("bp_all_written", 80'(n_we - w0), 80'(n_acc - a0));
    check("bp_drained", 80'(acc_q.size()), 80'd0);
    check("bp_no_ovf", 80'(overflow), 80'd0);

    // Full ring of eight.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    w0 = n_we;
    for (int k = 0; k < 8; k++) begin
      push(mk(20 + k));
      tick(); tick();
    end
    push(mk(28));
    check("ring9_we", 80'(write_enable), 80'(OVR));
    if (OVR) check("ring9_addr", 80'(s_addr), 80'd0);
    repeat (3) tick();
    check("ring_count", 80'(rec_count), 80'd8);
    check("ring_ovf", 80'(overflow), 80'(!OVR));
    check("ring_writes", 80'(n_we - w0), OVR ? 80'd9 : 80'd8);
    do_read(3'd7, 1'b0, '0, 1'b0, 3);
    m = mk(OVR ? 21 : 20);
    check("ring_oldest", 80'(o_tns), 80'(m.tns));
    do_read(3'd0, 1'b0, '0, 1'b0, 3);
    m = mk(OVR ? 28 : 27);
    check("ring_newest", 80'(o_dtime), 80'(m.dt));
    check("end_drained", 80'(acc_q.size()), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
